// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP encodings: FMA opcodes, rounding modes, fflags, fma_op
package fp_pkg;

   localparam logic [6:0] OPC_FMADD  = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD = 7'b1001111;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100,
      RM_DYN = 3'b111
   } rm_e;

   localparam int FFLAG_NX = 0;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_NV = 4;

   typedef enum logic [1:0] {
      FMA_OP_MADD  = 2'b00,
      FMA_OP_MSUB  = 2'b01,
      FMA_OP_NMSUB = 2'b10,
      FMA_OP_NMADD = 2'b11
   } fma_op_e;

   typedef struct packed {
      logic    valid;
      fma_op_e op;
   } fma_dec_t;

   function automatic fma_dec_t decode_fma_opcode(input logic [6:0] opc);
      fma_dec_t dec;
      dec.valid = 1'b1;
      dec.op    = FMA_OP_MADD;
      case (opc)
         OPC_FMADD:  dec.op = FMA_OP_MADD;
         OPC_FMSUB:  dec.op = FMA_OP_MSUB;
         OPC_FNMSUB: dec.op = FMA_OP_NMSUB;
         OPC_FNMADD: dec.op = FMA_OP_NMADD;
         default:    dec.valid = 1'b0;
      endcase
      return dec;
   endfunction

   // Only RNE..RMM are real static modes; 101/110 are reserved and DYN must already be resolved.
   function automatic logic rm_is_static(input logic [2:0] rm);
      return rm <= RM_RMM;
   endfunction

endpackage

// File: rtl/fp_fma_seq.sv
// rtl/fp_fma_seq.sv - issue/writeback sequencer in front of the fused multiply-add unit
module fp_fma_seq
   import fp_pkg::*;
#(
   parameter int FLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      req_opcode,
   input  logic [2:0]      req_rm,
   input  logic [4:0]      req_rd,
   input  logic [FLEN-1:0] req_rs1,
   input  logic [FLEN-1:0] req_rs2,
   input  logic [FLEN-1:0] req_rs3,
   input  logic [2:0]      frm,
   output logic            fma_start,
   output logic [1:0]      fma_op,
   output logic [2:0]      fma_rm,
   output logic [FLEN-1:0] fma_a,
   output logic [FLEN-1:0] fma_b,
   output logic [FLEN-1:0] fma_c,
   input  logic            fma_busy,
   input  logic            fma_done,
   input  logic [FLEN-1:0] fma_result,
   input  logic            fma_nv,
   input  logic            fma_of,
   input  logic            fma_uf,
   input  logic            fma_nx,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [4:0]      wb_rd,
   output logic [FLEN-1:0] wb_data,
   output logic [4:0]      wb_fflags,
   output logic            illegal
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DRAIN,
      ST_WB
   } state_e;

   state_e          state_q, state_d;
   logic [FLEN-1:0] fma_a_q, fma_a_d;
   logic [FLEN-1:0] fma_b_q, fma_b_d;
   logic [FLEN-1:0] fma_c_q, fma_c_d;
   fma_op_e         fma_op_q, fma_op_d;
   logic [2:0]      fma_rm_q, fma_rm_d;
   logic [4:0]      rd_q, rd_d;
   logic            legal_q, legal_d;
   logic [FLEN-1:0] wb_data_q, wb_data_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [4:0]      wb_fflags_q, wb_fflags_d;

   logic            accept;
   logic [2:0]      rm_eff;
   fma_dec_t        dec;
   logic [4:0]      flags_now;

   // Gated by reset_n so every output reads 0 while reset is held.
   assign req_ready = reset_n && (state_q == ST_IDLE) && !flush;
   assign fma_start = (state_q == ST_ISSUE) && legal_q && !flush;
   assign illegal   = (state_q == ST_ISSUE) && !legal_q && !flush;
   assign wb_valid  = (state_q == ST_WB) && !flush;

   assign fma_a     = fma_a_q;
   assign fma_b     = fma_b_q;
   assign fma_c     = fma_c_q;
   assign fma_op    = fma_op_q;
   assign fma_rm    = fma_rm_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign wb_fflags = wb_fflags_q;

   always_comb begin
      state_d     = state_q;
      fma_a_d     = fma_a_q;
      fma_b_d     = fma_b_q;
      fma_c_d     = fma_c_q;
      fma_op_d    = fma_op_q;
      fma_rm_d    = fma_rm_q;
      rd_d        = rd_q;
      legal_d     = legal_q;
      wb_data_d   = wb_data_q;
      wb_rd_d     = wb_rd_q;
      wb_fflags_d = wb_fflags_q;

      accept = req_valid && req_ready;
      rm_eff = (req_rm == RM_DYN) ? frm : req_rm;
      dec    = decode_fma_opcode(req_opcode);

      flags_now           = '0;
      flags_now[FFLAG_NV] = fma_nv;
      flags_now[FFLAG_DZ] = 1'b0;
      flags_now[FFLAG_OF] = fma_of;
      flags_now[FFLAG_UF] = fma_uf;
      flags_now[FFLAG_NX] = fma_nx;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               fma_a_d  = req_rs1;
               fma_b_d  = req_rs2;
               fma_c_d  = req_rs3;
               fma_op_d = dec.op;
               fma_rm_d = rm_eff;
               rd_d     = req_rd;
               legal_d  = dec.valid && rm_is_static(rm_eff);
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (flush || !legal_q) state_d = ST_IDLE;
            else                   state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // The FMA cannot be aborted, so a flush must still wait for its done.
            if (flush && fma_done) begin
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end else if (fma_done) begin
               wb_data_d   = fma_result;
               wb_rd_d     = rd_q;
               wb_fflags_d = flags_now;
               state_d     = ST_WB;
            end
         end
         ST_DRAIN: begin
            if (fma_done) state_d = ST_IDLE;
         end
         ST_WB: begin
            if (flush || wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         fma_a_q     <= '0;
         fma_b_q     <= '0;
         fma_c_q     <= '0;
         fma_op_q    <= FMA_OP_MADD;
         fma_rm_q    <= '0;
         rd_q        <= '0;
         legal_q     <= 1'b0;
         wb_data_q   <= '0;
         wb_rd_q     <= '0;
         wb_fflags_q <= '0;
      end else begin
         state_q     <= state_d;
         fma_a_q     <= fma_a_d;
         fma_b_q     <= fma_b_d;
         fma_c_q     <= fma_c_d;
         fma_op_q    <= fma_op_d;
         fma_rm_q    <= fma_rm_d;
         rd_q        <= rd_d;
         legal_q     <= legal_d;
         wb_data_q   <= wb_data_d;
         wb_rd_q     <= wb_rd_d;
         wb_fflags_q <= wb_fflags_d;
      end
   end

   property p_busy_in_wait;
      @(posedge clk) disable iff (!reset_n)
         (state_q == ST_WAIT && !fma_done) |-> fma_busy;
   endproperty
   a_busy_in_wait: assert property (p_busy_in_wait);

endmodule

// File: tb/tb_fp_fma_seq.sv
// tb/tb_fp_fma_seq.sv - randomized self-checking bench for fp_fma_seq with an FMA stand-in
module tb_fp_fma_seq;

   localparam int FLEN = 32;
   localparam logic [6:0] OP_MADD  = 7'b1000011;
   localparam logic [6:0] OP_MSUB  = 7'b1000111;
   localparam logic [6:0] OP_NMSUB = 7'b1001011;
   localparam logic [6:0] OP_NMADD = 7'b1001111;

   logic            clk = 1'b0;
   logic            reset_n, flush, req_valid, req_ready;
   logic [6:0]      req_opcode;
   logic [2:0]      req_rm, frm;
   logic [4:0]      req_rd;
   logic [FLEN-1:0] req_rs1, req_rs2, req_rs3;
   logic            fma_start;
   logic [1:0]      fma_op;
   logic [2:0]      fma_rm;
   logic [FLEN-1:0] fma_a, fma_b, fma_c;
   logic            fma_busy, fma_done;
   logic [FLEN-1:0] fma_result;
   logic            fma_nv, fma_of, fma_uf, fma_nx;
   logic            wb_valid, wb_ready;
   logic [4:0]      wb_rd, wb_fflags;
   logic [FLEN-1:0] wb_data;
   logic            illegal;

   logic            model_done, spur_done;
   logic [3:0]      model_flags;
   int              n_checks = 0;
   int              n_errors = 0;

   assign fma_done = model_done | spur_done;

   always #5 clk = ~clk;

   fp_fma_seq #(.FLEN(FLEN)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_rm(req_rm), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_rs3(req_rs3), .frm(frm),
      .fma_start(fma_start), .fma_op(fma_op), .fma_rm(fma_rm),
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
      .fma_busy(fma_busy), .fma_done(fma_done), .fma_result(fma_result),
      .fma_nv(fma_nv), .fma_of(fma_of), .fma_uf(fma_uf), .fma_nx(fma_nx),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_fflags(wb_fflags), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic real s2r(input logic [31:0] s);
      logic [63:0] d;
      if (s[30:0] == 31'd0) d = {s[31], 63'd0};
      else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   // Stand-in arithmetic for the FMA unit: a*b then sign/addend per RISC-V op.
   function automatic logic [31:0] fma_ref(input logic [1:0] op, input logic [31:0] a, b, c);
      real p, cc, r;
      p  = s2r(a) * s2r(b);
      cc = s2r(c);
      case (op)
         2'd0:    r = p + cc;
         2'd1:    r = p - cc;
         2'd2:    r = -p + cc;
         default: r = -p - cc;
      endcase
      return r2s(r);
   endfunction

   function automatic int ref_op(input logic [6:0] opc);
      case (opc)
         OP_MADD:  return 0;
         OP_MSUB:  return 1;
         OP_NMSUB: return 2;
         OP_NMADD: return 3;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // FMA unit model: samples start, busy for 5 cycles, done pulse 6 cycles after start.
   initial begin
      int cnt;
      logic st;
      logic [1:0] op;
      logic [31:0] a, b, c;
      logic [3:0] fl;
      cnt = 0; st = 0; op = 0; a = 0; b = 0; c = 0; fl = 0;
      model_done = 0; fma_busy = 0; fma_result = '0;
      {fma_nv, fma_of, fma_uf, fma_nx} = 4'b0;
      forever begin
         @(negedge clk);
         st = fma_start && reset_n;
         if (st) begin op = fma_op; a = fma_a; b = fma_b; c = fma_c; fl = model_flags; end
         @(posedge clk);
         #1;
         if (cnt > 0) cnt--;
         if (st) begin
            cnt = 6;
            fma_result = fma_ref(op, a, b, c);
            {fma_nv, fma_of, fma_uf, fma_nx} = fl;
         end
         if (!reset_n) cnt = 0;
         fma_busy   = (cnt > 1);
         model_done = (cnt == 1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 0; flush = 0; req_valid = 0; wb_ready = 0;
      repeat (2) step();
      reset_n = 1;
      step();
   endtask

   // Leaves the bench in cycle 1 (just after the accepting edge).
   task automatic issue(input logic [6:0] opc, input logic [2:0] rm, input logic [4:0] rd,
                        input logic [31:0] a, b, c);
      step();
      req_valid = 1; req_opcode = opc; req_rm = rm; req_rd = rd;
      req_rs1 = a; req_rs2 = b; req_rs3 = c;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      step();
      req_valid = 0;
   endtask

   task automatic run_op(input logic [6:0] opc, input logic [2:0] rm, input logic [2:0] fr,
                         input logic [4:0] rd, input logic [31:0] a, b, c,
                         input logic [3:0] fl, input int bp);
      int eop, cyc, extra, bad;
      logic [2:0] rm_eff;
      logic legal;
      logic [31:0] exp_data;
      logic [4:0] exp_ff;
      eop      = ref_op(opc);
      rm_eff   = (rm == 3'b111) ? fr : rm;
      legal    = (eop >= 0) && (rm_eff <= 3'd4);
      exp_data = fma_ref(2'(eop), a, b, c);
      exp_ff   = {fl[3], 1'b0, fl[2:0]};
      model_flags = fl; frm = fr; wb_ready = (bp == 0);
      issue(opc, rm, rd, a, b, c);
      @(negedge clk);
      if (!legal) begin
         chk("illegal_pulse", illegal, 1);
         chk("illegal_no_start", fma_start, 0);
         step();
         @(negedge clk);
         chk("illegal_ready_c2", req_ready, 1);
         chk("illegal_quiet_c2", {illegal, fma_start, wb_valid}, 0);
         return;
      end
      chk("start_c1", fma_start, 1);
      chk("fma_op", fma_op, 64'(eop));
      chk("fma_rm", fma_rm, rm_eff);
      chk("fma_ab", {fma_a, fma_b}, {a, b});
      chk("fma_c", fma_c, c);
      chk("no_illegal", illegal, 0);
      cyc = 1; extra = 0;
      while (!wb_valid && cyc < 30) begin
         step();
         @(negedge clk);
         cyc++;
         if (fma_start) extra++;
      end
      chk("latency", cyc, 8);
      chk("single_start", extra, 0);
      if (!wb_valid) begin
         do_reset();
         return;
      end
      chk("wb_data", wb_data, exp_data);
      chk("wb_rd", wb_rd, rd);
      chk("wb_fflags", wb_fflags, exp_ff);
      bad = 0;
      for (int i = 0; i < bp; i++) begin
         step();
         @(negedge clk);
         if ({wb_valid, req_ready, wb_data, wb_rd, wb_fflags} !== {1'b1, 1'b0, exp_data, rd, exp_ff})
            bad++;
      end
      if (bp > 0) chk("bp_stable", bad, 0);
      wb_ready = 1;
      step();
      @(negedge clk);
      chk("post_handshake", {wb_valid, req_ready}, 2'b01);
   endtask

   task automatic flush_op(input int fcyc);
      int cyc, seen_wb;
      frm = 0; wb_ready = 1; model_flags = 0;
      issue(OP_MADD, 3'b000, 5'd3, rand_fp(), rand_fp(), rand_fp());
      cyc = 1;
      while (cyc < fcyc) begin step(); cyc++; end
      flush = 1;
      @(negedge clk);
      chk("flush_ready_low", req_ready, 0);
      step();
      flush = 0;
      cyc++;
      seen_wb = 0;
      @(negedge clk);
      while (!req_ready && cyc < 30) begin
         if (wb_valid) seen_wb++;
         step();
         cyc++;
         @(negedge clk);
      end
      if (wb_valid) seen_wb++;
      chk("flush_ready_cycle", cyc, 8);
      chk("flush_no_wb", seen_wb, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [6:0] ops [4];
      logic [6:0] opc;
      ops = '{OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD};
      reset_n = 0; flush = 0; req_valid = 0; req_opcode = 0; req_rm = 0; req_rd = 0;
      req_rs1 = 0; req_rs2 = 0; req_rs3 = 0; frm = 0; wb_ready = 0;
      spur_done = 0; model_flags = 0;

      repeat (2) step();
      @(negedge clk);
      chk("rst_ctrl", {req_ready, fma_start, fma_op, fma_rm, wb_valid, wb_rd, wb_fflags, illegal}, 0);
      chk("rst_data", fma_a | fma_b | fma_c | wb_data, 0);
      step();
      reset_n = 1;
      @(negedge clk);
      chk("rst_release_ready", req_ready, 1);

      run_op(OP_MADD, 3'b000, 3'b000, 5'd7, 32'h40000000, 32'h40400000, 32'h3F800000, 4'b0000, 0);
      run_op(OP_MSUB, 3'b111, 3'b011, 5'd9, rand_fp(), rand_fp(), rand_fp(), 4'b0000, 0);
      run_op(OP_MADD, 3'b111, 3'b101, 5'd9, rand_fp(), rand_fp(), rand_fp(), 4'b0000, 0);
      run_op(OP_NMADD, 3'b001, 3'b000, 5'd12, rand_fp(), rand_fp(), rand_fp(), 4'b1001, 0);
      run_op(OP_NMSUB, 3'b010, 3'b000, 5'd30, rand_fp(), rand_fp(), rand_fp(), 4'b0110, 5);

      flush_op(4);
      run_op(OP_MSUB, 3'b100, 3'b000, 5'd5, rand_fp(), rand_fp(), rand_fp(), 4'b0010, 0);
      flush_op(7);
      run_op(OP_MADD, 3'b000, 3'b000, 5'd6, rand_fp(), rand_fp(), rand_fp(), 4'b0000, 1);

      // Reset while the FMA is in flight.
      model_flags = 0; wb_ready = 1;
      issue(OP_MADD, 3'b000, 5'd21, rand_fp(), rand_fp(), rand_fp());
      repeat (3) step();
      reset_n = 0;
      #1;
      chk("midrst_ctrl", {req_ready, fma_start, fma_op, fma_rm, wb_valid, wb_rd, wb_fflags, illegal}, 0);
      chk("midrst_data", fma_a | fma_b | fma_c | wb_data, 0);
      repeat (2) step();
      reset_n = 1;
      run_op(OP_NMADD, 3'b011, 3'b000, 5'd22, rand_fp(), rand_fp(), rand_fp(), 4'b0100, 0);

      // Spurious done while idle must be ignored.
      step();
      spur_done = 1;
      @(negedge clk);
      chk("spur_ready", req_ready, 1);
      step();
      spur_done = 0;
      @(negedge clk);
      chk("spur_quiet", {wb_valid, req_ready}, 2'b01);

      for (int i = 0; i < 30; i++) begin
         opc = ops[$urandom_range(0, 3)];
         if ($urandom_range(0, 7) == 0) opc = 7'b1010011;
         run_op(opc, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom),
                rand_fp(), rand_fp(), rand_fp(), 4'($urandom), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
